shift_pattern_detector: RTL



---
 rtl/shift_pattern_detector_pkg.sv | 9 +
 rtl/shift_pattern_window.sv | 67 ++++++
 rtl/shift_pattern_detector.sv | 56 +++++
 3 files changed

// File: rtl/shift_pattern_detector_pkg.sv
// Shared constants for the serial shift register / pattern detector.
package shift_pattern_detector_pkg;
    localparam logic       DIR_RIGHT   = 1'b0;
    localparam logic       DIR_LEFT    = 1'b1;
    localparam int         DEF_WIDTH   = 10;
    localparam int         DEF_PAT_LEN = 2;
    localparam logic [1:0] DEF_PATTERN = 2'b01;
    localparam int         DEF_CNT_W   = 8;
endpackage

// File: rtl/shift_pattern_window.sv
// Sliding window over the bits leaving the shift register; flags and counts pattern hits.
module shift_pattern_window
    import shift_pattern_detector_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter int                 CNT_W   = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             shift_strobe,
    input  logic             flush,
    input  logic             bit_in,
    input  logic             clear_count,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);
    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_match;
    logic [CNT_W-1:0]   r_count;

    logic [PAT_LEN-1:0] w_hist_next;
    logic [FILL_W-1:0]  w_fill_next;
    logic               w_hit;

    generate
        if (PAT_LEN == 1) begin : g_hist1
            assign w_hist_next = bit_in;
        end else begin : g_histn
            assign w_hist_next = {r_hist[PAT_LEN-2:0], bit_in};
        end
    endgenerate

    // fill gates hits until a full pattern's worth of bits has been seen since reset/load
    assign w_fill_next = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
    assign w_hit       = shift_strobe && (w_hist_next == PATTERN) && (w_fill_next == FILL_FULL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
            r_count <= '0;
        end else begin
            if (flush) begin
                r_hist  <= '0;
                r_fill  <= '0;
                r_match <= 1'b0;
            end else if (shift_strobe) begin
                r_hist  <= w_hist_next;
                r_fill  <= w_fill_next;
                r_match <= w_hit;
            end
            if (clear_count)
                r_count <= '0;
            else if (w_hit && (r_count != '1))
                r_count <= r_count + CNT_W'(1);
        end
    end

    assign match       = r_match;
    assign match_count = r_count;
endmodule

// File: rtl/shift_pattern_detector.sv
// Bidirectional shift register with parallel load, watching its own serial output for a pattern.
module shift_pattern_detector
    import shift_pattern_detector_pkg::*;
#(
    parameter int                 WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VALUE = WIDTH'(1) << (WIDTH - 1),
    parameter int                 PAT_LEN     = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN     = PAT_LEN'(DEF_PATTERN),
    parameter int                 CNT_W       = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic             in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clear_count,
    output logic [WIDTH-1:0] data,
    output logic             out,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);
    logic [WIDTH-1:0] r_data;
    logic             w_shift;

    // load wins over a simultaneous shift request
    assign w_shift = enable & ~load;
    assign out     = (dir == DIR_LEFT) ? r_data[WIDTH-1] : r_data[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_data <= RESET_VALUE;
        else if (load)
            r_data <= load_data;
        else if (w_shift)
            r_data <= (dir == DIR_LEFT) ? {r_data[WIDTH-2:0], in} : {in, r_data[WIDTH-1:1]};
    end

    shift_pattern_window #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .CNT_W   (CNT_W)
    ) u_window (
        .clock        (clock),
        .reset        (reset),
        .shift_strobe (w_shift),
        .flush        (load),
        .bit_in       (out),
        .clear_count  (clear_count),
        .match        (match),
        .match_count  (match_count)
    );

    assign data = r_data;
endmodule
